// File: rtl/fetch_pipe_ctrl_pkg.sv
// Purpose : shared constants for the fetch front end, decoder and hazard unit.
// Latency : n/a (constants only).
// Backpr. : n/a.
// Contents: NOP encoding, reset PC default, control-bundle width and bit map.
package fetch_pipe_ctrl_pkg;

    // All-zero instruction doubles as the bubble loaded on a squash.
    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    // Decoded control bundle passed ID->EX. Bit positions are shared with the
    // decoder (producer) and the hazard unit (taps memread in EX).
    localparam int unsigned CTRL_W_DEF        = 8;
    localparam int unsigned CTRL_REGWRITE_BIT = 0;
    localparam int unsigned CTRL_MEMREAD_BIT  = 1;
    localparam int unsigned CTRL_MEMWRITE_BIT = 2;
    localparam int unsigned CTRL_BRANCH_BIT   = 3;
    localparam int unsigned CTRL_ALUSRC_BIT   = 4;
    localparam int unsigned CTRL_ALUOP_LSB    = 5;
    localparam int unsigned CTRL_ALUOP_W      = 3;

endpackage

// File: rtl/fetch_pipe_ctrl_pipe_reg.sv
// Purpose : generic pipeline register with enable and synchronous clear.
// Latency : 1 cycle from d to q.
// Backpr. : en=0 holds the current contents; clr overrides en.
// Ports   : clk, rst_n (async, active-low, loads RST_VAL), en, clr, d -> q.
module pipe_reg #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Clear wins over enable: a squash must land even while the stage is held.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Purpose : PC, IF/ID and ID/EX control registers driven by hazard stall/flush and branch redirect.
// Latency : every input acts at the next rising edge; all outputs are registered.
// Backpr. : PCwrite=0 holds pc, Id_write=0 holds IF/ID; ctrl_flush/br_taken insert bubbles.
// Ports   : clk, rst_n; PCwrite, Id_write, ctrl_flush, br_taken, br_target, if_instr, id_ctrl_in
//           -> pc, id_instr, id_pc_plus1, id_valid, ex_ctrl, stall_cnt.
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int unsigned       PC_W     = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter int unsigned       CTRL_W   = CTRL_W_DEF,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCwrite,
    input  logic               Id_write,
    input  logic               ctrl_flush,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [CTRL_W-1:0]  id_ctrl_in,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc_plus1,
    output logic               id_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_RST = '{instr: INSTR_W'(NOP_INSTR), pc_plus1: '0, valid: 1'b0};

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_plus1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    ifid_t            ifid_in;
    ifid_t            ifid_out;
    logic             idex_clr;

    // Natural PC_W-bit arithmetic gives the required wrap at all-ones.
    assign pc_plus1 = pc_q + PC_W'(1);

    // A resolved branch is older than any ID-stage hazard, so it wins over a held PC.
    always_comb begin
        pc_d = pc_q;
        if (br_taken) begin
            pc_d = br_target;
        end else if (PCwrite) begin
            pc_d = pc_plus1;
        end
    end

    // Only genuine hazard holds count; a redirect cycle is not a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCwrite && !br_taken && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // IF/ID: squashed by a branch, held by Id_write=0. The pc+1 captured here is the
    // sequential PC of the instruction being fetched now.
    assign ifid_in = '{instr: if_instr, pc_plus1: pc_plus1, valid: 1'b1};

    pipe_reg #(
        .W       ($bits(ifid_t)),
        .RST_VAL (IFID_RST)
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (Id_write),
        .clr   (br_taken),
        .d     (ifid_in),
        .q     (ifid_out)
    );

    // ID/EX: the bubble goes in on the same edge that the stall holds IF/ID, so the
    // held instruction enters EX exactly once, one cycle later. An empty IF/ID slot
    // must also never leak decoder output into EX.
    assign idex_clr = ctrl_flush | br_taken | ~ifid_out.valid;

    pipe_reg #(
        .W       (CTRL_W),
        .RST_VAL ('0)
    ) u_idex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (idex_clr),
        .d     (id_ctrl_in),
        .q     (ex_ctrl)
    );

    assign pc          = pc_q;
    assign id_instr    = ifid_out.instr;
    assign id_pc_plus1 = ifid_out.pc_plus1;
    assign id_valid    = ifid_out.valid;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Purpose : self-checking bench for fetch_pipe_ctrl (16-bit and 4-bit stall counter builds).
// Latency : n/a.
// Backpr. : n/a.
module tb_fetch_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCwrite, Id_write, ctrl_flush, br_taken;
    logic [15:0] br_target, if_instr;
    logic [7:0]  id_ctrl_in;

    logic [15:0] pc, id_instr, id_pc_plus1;
    logic        id_valid;
    logic [7:0]  ex_ctrl;
    logic [15:0] stall_cnt;

    logic [15:0] pc4, id_instr4, id_pc_plus14;
    logic        id_valid4;
    logic [7:0]  ex_ctrl4;
    logic [3:0]  stall_cnt4;

    always #5 clk = ~clk;

    fetch_pipe_ctrl #(.PC_W(16), .INSTR_W(16), .CTRL_W(8), .RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCwrite(PCwrite), .Id_write(Id_write),
        .ctrl_flush(ctrl_flush), .br_taken(br_taken), .br_target(br_target),
        .if_instr(if_instr), .id_ctrl_in(id_ctrl_in), .pc(pc), .id_instr(id_instr),
        .id_pc_plus1(id_pc_plus1), .id_valid(id_valid), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    fetch_pipe_ctrl #(.PC_W(16), .INSTR_W(16), .CTRL_W(8), .RESET_PC(16'h0000), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .PCwrite(PCwrite), .Id_write(Id_write),
        .ctrl_flush(ctrl_flush), .br_taken(br_taken), .br_target(br_target),
        .if_instr(if_instr), .id_ctrl_in(id_ctrl_in), .pc(pc4), .id_instr(id_instr4),
        .id_pc_plus1(id_pc_plus14), .id_valid(id_valid4), .ex_ctrl(ex_ctrl4), .stall_cnt(stall_cnt4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_lost  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Saturating view of an unbounded count.
    function automatic logic [15:0] sat(input int unsigned v, input int unsigned w);
        int unsigned mx;
        mx = (32'd1 << w) - 32'd1;
        return (v > mx) ? 16'(mx) : 16'(v);
    endfunction

    // Reference model: architectural state of the front end, one step per edge.
    logic [15:0] m_pc, m_instr, m_pc1;
    logic        m_valid;
    logic [7:0]  m_ex;
    int unsigned m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 16'h0000;
            m_instr <= 16'h0000;
            m_pc1   <= 16'h0000;
            m_valid <= 1'b0;
            m_ex    <= 8'h00;
            m_cnt   <= 0;
        end else begin
            m_ex <= (ctrl_flush || br_taken || !m_valid) ? 8'h00 : id_ctrl_in;
            if (br_taken) begin
                m_instr <= 16'h0000;
                m_pc1   <= 16'h0000;
                m_valid <= 1'b0;
            end else if (Id_write) begin
                m_instr <= if_instr;
                m_pc1   <= 16'((32'(m_pc) + 1) % 65536);
                m_valid <= 1'b1;
            end
            if (br_taken)     m_pc <= br_target;
            else if (PCwrite) m_pc <= 16'((32'(m_pc) + 1) % 65536);
            if (!PCwrite && !br_taken) m_cnt <= m_cnt + 1;
        end
    end

    // Fetched-but-dropped instruction: legal for the RTL, only noted here.
    always @(posedge clk) begin
        if (rst_n && PCwrite && !Id_write && !br_taken) n_lost++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",           pc,           m_pc);
            chk("id_instr",     id_instr,     m_instr);
            chk("id_pc_plus1",  id_pc_plus1,  m_pc1);
            chk("id_valid",     id_valid,     m_valid);
            chk("ex_ctrl",      ex_ctrl,      m_ex);
            chk("stall_cnt",    stall_cnt,    sat(m_cnt, 16));
            chk("pc_c4",        pc4,          m_pc);
            chk("id_instr_c4",  id_instr4,    m_instr);
            chk("id_pc1_c4",    id_pc_plus14, m_pc1);
            chk("id_valid_c4",  id_valid4,    m_valid);
            chk("ex_ctrl_c4",   ex_ctrl4,     m_ex);
            chk("stall_cnt_c4", stall_cnt4,   sat(m_cnt, 4));
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic pcw, input logic idw, input logic fl, input logic br);
        PCwrite = pcw; Id_write = idw; ctrl_flush = fl; br_taken = br;
    endtask

    initial begin
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        br_target  = 16'h0000;
        if_instr   = 16'h1234;
        id_ctrl_in = 8'hA5;
        repeat (2) edge_step();
        chk_en = 1'b1;

        chk("rst_pc",        pc,          16'h0000);
        chk("rst_id_instr",  id_instr,    16'h0000);
        chk("rst_id_pc1",    id_pc_plus1, 16'h0000);
        chk("rst_id_valid",  id_valid,    1'b0);
        chk("rst_ex_ctrl",   ex_ctrl,     8'h00);
        chk("rst_stall_cnt", stall_cnt,   16'h0000);

        // Plain fetch from reset.
        rst_n = 1'b1;
        edge_step();
        chk("e1_pc",       pc,          16'h0001);
        chk("e1_id_valid", id_valid,    1'b1);
        chk("e1_id_pc1",   id_pc_plus1, 16'h0001);
        chk("e1_id_instr", id_instr,    16'h1234);
        chk("e1_ex_ctrl",  ex_ctrl,     8'h00);
        edge_step();
        chk("e2_pc",       pc,          16'h0002);
        chk("e2_id_pc1",   id_pc_plus1, 16'h0002);
        chk("e2_ex_ctrl",  ex_ctrl,     8'hA5);
        edge_step();
        chk("e3_pc",       pc,          16'h0003);
        repeat (2) edge_step();
        chk("e5_pc",       pc,          16'h0005);

        // Load-use stall at pc=5.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        edge_step();
        chk("ld_pc",        pc,          16'h0005);
        chk("ld_id_pc1",    id_pc_plus1, 16'h0005);
        chk("ld_id_valid",  id_valid,    1'b1);
        chk("ld_ex_ctrl",   ex_ctrl,     8'h00);
        chk("ld_stall_cnt", stall_cnt,   16'h0001);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        id_ctrl_in = 8'h3C;
        edge_step();
        chk("ld2_pc",       pc,          16'h0006);
        chk("ld2_ex_ctrl",  ex_ctrl,     8'h3C);
        chk("ld2_id_pc1",   id_pc_plus1, 16'h0006);

        // Branch together with a stall: branch wins, no stall counted.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        br_target = 16'h0040;
        edge_step();
        chk("br_pc",        pc,          16'h0040);
        chk("br_id_valid",  id_valid,    1'b0);
        chk("br_id_instr",  id_instr,    16'h0000);
        chk("br_id_pc1",    id_pc_plus1, 16'h0000);
        chk("br_ex_ctrl",   ex_ctrl,     8'h00);
        chk("br_stall_cnt", stall_cnt,   16'h0001);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        edge_step();
        chk("br2_pc",       pc,          16'h0041);
        chk("br2_id_valid", id_valid,    1'b1);
        chk("br2_ex_ctrl",  ex_ctrl,     8'h00);

        // PC wrap.
        set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
        br_target = 16'hFFFF;
        edge_step();
        chk("wr_pc_ffff",   pc,          16'hFFFF);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        edge_step();
        chk("wr_pc",        pc,          16'h0000);
        chk("wr_id_pc1",    id_pc_plus1, 16'h0000);
        chk("wr_id_valid",  id_valid,    1'b1);

        // Saturation of the 4-bit counter build.
        chk("sat_start_c4", stall_cnt4, 4'h1);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (14) edge_step();
        chk("sat_c4",       stall_cnt4, 4'hF);
        chk("sat_c16",      stall_cnt,  16'd15);
        repeat (3) edge_step();
        chk("sat_hold_c4",  stall_cnt4, 4'hF);
        chk("sat_hold_c16", stall_cnt,  16'd18);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic hold;
            hold = ($urandom_range(3) == 0);
            PCwrite  = !hold;
            Id_write = !hold;
            if ($urandom_range(15) == 0) Id_write = ~Id_write;
            ctrl_flush = hold ? 1'b1 : ($urandom_range(7) == 0);
            br_taken   = ($urandom_range(7) == 0);
            br_target  = ($urandom_range(3) == 0) ? (16'hFFF0 + 16'($urandom_range(15)))
                                                   : 16'($urandom);
            if_instr   = 16'($urandom);
            id_ctrl_in = 8'($urandom);
            edge_step();
        end

        // Async reset in the middle of a stall: outputs clear before the next edge.
        set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
        br_target = 16'h0123;
        edge_step();
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_pc",        pc,          16'h0000);
        chk("ar_id_instr",  id_instr,    16'h0000);
        chk("ar_id_pc1",    id_pc_plus1, 16'h0000);
        chk("ar_id_valid",  id_valid,    1'b0);
        chk("ar_ex_ctrl",   ex_ctrl,     8'h00);
        chk("ar_stall_cnt", stall_cnt,   16'h0000);
        chk("ar_stall_c4",  stall_cnt4,  4'h0);
        edge_step();
        rst_n = 1'b1;
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        if_instr = 16'h5A5A;
        edge_step();
        chk("ar2_pc",       pc,          16'h0001);
        chk("ar2_id_pc1",   id_pc_plus1, 16'h0001);
        chk("ar2_id_instr", id_instr,    16'h5A5A);
        repeat (2) edge_step();

        chk_en = 1'b0;
        $display("[TB] note: %0d cycles advanced pc while holding IF/ID (fetched instruction dropped)", n_lost);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
